dma_desc_queue: RTL and testbench

//  Descriptor front-end directly upstream of the DMA functional wrapper. It buffers up to DEPTH

---
 rtl/dma_desc_queue.sv | 122 ++++++++++++
 tb/tb_dma_desc_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_desc_queue.sv
// Descriptor queue in front of the DMA wrapper. Holds up to DEPTH descriptors and launches one at a time.
// It waits for completion or error, counts both, and raises an interrupt pulse.
package dma_desc_pkg;
    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] num_bytes;
    } s_dma_desc_t;
endpackage

module dma_desc_queue
    import dma_desc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     desc_valid_i,
    output logic                     desc_ready_o,
    input  s_dma_desc_t              desc_i,
    input  logic                     flush_i,
    input  logic                     err_clear_i,
    output logic                     dma_go_o,
    output s_dma_desc_t              dma_desc_o,
    input  logic                     dma_done_i,
    input  logic                     dma_error_i,
    output logic                     busy_o,
    output logic                     halted_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [CNT_W-1:0]         done_cnt_o,
    output logic [CNT_W-1:0]         err_cnt_o,
    output logic                     irq_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    logic [1:0]  state;
    logic [AW:0] wr_ptr, rd_ptr;
    s_dma_desc_t mem [0:DEPTH-1];
    s_dma_desc_t head;
    logic        full, empty, push, pop;
    logic        done_q, err_q, done_rise, err_rise;

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    // Flush takes priority over both ends of the FIFO in the same cycle.
    assign push      = desc_valid_i && !full && !flush_i;
    assign pop       = (state == S_IDLE) && !empty && !flush_i;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign done_rise = dma_done_i && !done_q;
    assign err_rise  = dma_error_i && !err_q;

    assign desc_ready_o = !full;
    assign dma_go_o     = (state == S_LAUNCH);
    assign busy_o       = (state != S_IDLE) || !empty;
    assign halted_o     = (state == S_HALT);
    assign level_o      = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= desc_i;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (flush_i)  rd_ptr <= wr_ptr;
            else if (pop) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            dma_desc_o <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            done_cnt_o <= '0;
            err_cnt_o  <= '0;
            irq_o      <= 1'b0;
        end else begin
            // Edge registers track in every state, so a level that rose during LAUNCH never fires later.
            done_q <= dma_done_i;
            err_q  <= dma_error_i;
            irq_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        dma_desc_o <= head;
                        if (head.num_bytes == '0) done_cnt_o <= done_cnt_o + CNT_ONE;
                        else                      state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: state <= S_RUN;
                S_RUN: begin
                    if (err_rise) begin
                        err_cnt_o <= err_cnt_o + CNT_ONE;
                        irq_o     <= 1'b1;
                        state     <= S_HALT;
                    end else if (done_rise) begin
                        done_cnt_o <= done_cnt_o + CNT_ONE;
                        irq_o      <= empty;
                        state      <= S_IDLE;
                    end
                end
                S_HALT: if (err_clear_i) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_desc_queue.sv
// Directed bench for dma_desc_queue. A monitor process pops the expected descriptor on each go pulse.
// The directed sequence checks counters, levels and flags against hand-computed values.
module tb_dma_desc_queue;
    import dma_desc_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic        clk = 1'b0, rstn = 1'b0;
    logic        desc_valid_i = 1'b0, flush_i = 1'b0, err_clear_i = 1'b0;
    logic        dma_done_i = 1'b0, dma_error_i = 1'b0;
    s_dma_desc_t desc_i = '0;
    logic        desc_ready_o, dma_go_o, busy_o, halted_o, irq_o;
    s_dma_desc_t dma_desc_o;
    logic [$clog2(DEPTH):0] level_o;
    logic [CNT_W-1:0]       done_cnt_o, err_cnt_o;

    dma_desc_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o), .desc_i(desc_i),
        .flush_i(flush_i), .err_clear_i(err_clear_i),
        .dma_go_o(dma_go_o), .dma_desc_o(dma_desc_o),
        .dma_done_i(dma_done_i), .dma_error_i(dma_error_i),
        .busy_o(busy_o), .halted_o(halted_o), .level_o(level_o),
        .done_cnt_o(done_cnt_o), .err_cnt_o(err_cnt_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0, go_seen = 0, irq_seen = 0;
    int go0, irq0;
    s_dma_desc_t exp_q[$];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic s_dma_desc_t mk(input logic [31:0] s, input logic [31:0] d, input logic [15:0] b);
        s_dma_desc_t r;
        r.src = s;
        r.dst = d;
        r.num_bytes = b;
        return r;
    endfunction

    // Monitor: every go pulse must carry the next expected descriptor.
    always @(negedge clk) begin
        if (rstn && dma_go_o) begin
            go_seen++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL go_unexpected: got go with desc %0h expected no go", dma_desc_o);
            end else begin
                chk("go_desc", dma_desc_o, exp_q.pop_front());
            end
        end
        if (rstn && irq_o) irq_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        desc_valid_i = 1'b0; flush_i = 1'b0; err_clear_i = 1'b0;
        dma_done_i = 1'b0; dma_error_i = 1'b0;
        @(negedge clk);
        chk("rst_ready", desc_ready_o, 1);
        chk("rst_go", dma_go_o, 0);
        chk("rst_desc", dma_desc_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_halted", halted_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_done_cnt", done_cnt_o, 0);
        chk("rst_err_cnt", err_cnt_o, 0);
        chk("rst_irq", irq_o, 0);
        exp_q.delete();
        rstn = 1'b1;
        @(negedge clk);
        go0 = go_seen;
        irq0 = irq_seen;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input s_dma_desc_t d);
        int t = 0;
        desc_valid_i = 1'b1;
        desc_i = d;
        while (!desc_ready_o && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) chk("push_timeout", 0, 1);
        if (d.num_bytes != 0) exp_q.push_back(d);
        @(negedge clk);
        desc_valid_i = 1'b0;
    endtask

    task automatic wait_gos(input int n);
        int t = 0;
        while (go_seen < n && t < 100) begin @(negedge clk); #1; t++; end
        if (go_seen < n) chk("go_timeout", go_seen, n);
    endtask

    task automatic done_pulse;
        @(negedge clk); dma_done_i = 1'b1;
        @(negedge clk); dma_done_i = 1'b0;
    endtask

    s_dma_desc_t d1;

    initial begin
        // 1: single descriptor latency and completion
        do_reset;
        d1 = mk(32'h1000, 32'h2000, 16'h0040);
        desc_valid_i = 1'b1; desc_i = d1; exp_q.push_back(d1);
        @(negedge clk); desc_valid_i = 1'b0;
        chk("t1_level_after_push", level_o, 1);
        chk("t1_no_go_yet", dma_go_o, 0);
        chk("t1_busy", busy_o, 1);
        @(negedge clk);
        chk("t1_go_high", dma_go_o, 1);
        chk("t1_desc_out", dma_desc_o, d1);
        chk("t1_level_popped", level_o, 0);
        @(negedge clk);
        chk("t1_go_one_cycle", dma_go_o, 0);
        chk("t1_desc_stable", dma_desc_o, d1);
        dma_done_i = 1'b1;
        @(negedge clk); dma_done_i = 1'b0;
        chk("t1_done_cnt", done_cnt_o, 1);
        chk("t1_irq", irq_o, 1);
        chk("t1_busy_idle", busy_o, 0);
        @(negedge clk);
        chk("t1_irq_pulse", irq_o, 0);
        chk("t1_irq_count", irq_seen - irq0, 1);

        // 2: five back-to-back, full FIFO, ignored push while full
        do_reset;
        for (int i = 0; i < 5; i++) push(mk(32'h100 * i, 32'h8000 + i, 16'h10 + 16'(i)));
        chk("t2_ready_full", desc_ready_o, 0);
        chk("t2_level_full", level_o, 4);
        desc_valid_i = 1'b1; desc_i = mk(32'hDEAD, 32'hBEEF, 16'h1);
        @(negedge clk); desc_valid_i = 1'b0;
        chk("t2_push_while_full", level_o, 4);
        for (int i = 0; i < 5; i++) begin
            wait_gos(go0 + i + 1);
            if (i == 4) chk("t2_no_irq_before_last", irq_seen - irq0, 0);
            done_pulse;
        end
        tick(2);
        chk("t2_done_cnt", done_cnt_o, 5);
        chk("t2_go_count", go_seen - go0, 5);
        chk("t2_irq_once", irq_seen - irq0, 1);
        chk("t2_busy", busy_o, 0);

        // 3: error on the second of three, halt, clear, resume
        do_reset;
        for (int i = 0; i < 3; i++) push(mk(32'h3000 + i, 32'h4000 + i, 16'h20));
        wait_gos(go0 + 1);
        done_pulse;
        wait_gos(go0 + 2);
        @(negedge clk); dma_error_i = 1'b1;
        @(negedge clk); dma_error_i = 1'b0;
        chk("t3_err_cnt", err_cnt_o, 1);
        chk("t3_halted", halted_o, 1);
        chk("t3_level", level_o, 1);
        chk("t3_done_cnt_mid", done_cnt_o, 1);
        tick(6);
        chk("t3_no_go_halted", go_seen - go0, 2);
        chk("t3_still_halted", halted_o, 1);
        chk("t3_irq_err", irq_seen - irq0, 1);
        err_clear_i = 1'b1;
        @(negedge clk); err_clear_i = 1'b0;
        wait_gos(go0 + 3);
        done_pulse;
        chk("t3_done_cnt", done_cnt_o, 2);
        chk("t3_err_cnt_final", err_cnt_o, 1);
        chk("t3_not_halted", halted_o, 0);

        // 4: zero-length descriptor between two normal ones
        do_reset;
        push(mk(32'hA000, 32'hA100, 16'h10));
        push(mk(32'hB000, 32'hB100, 16'h0));
        push(mk(32'hC000, 32'hC100, 16'h20));
        wait_gos(go0 + 1);
        done_pulse;
        wait_gos(go0 + 2);
        done_pulse;
        tick(2);
        chk("t4_done_cnt", done_cnt_o, 3);
        chk("t4_go_count", go_seen - go0, 2);
        chk("t4_irq_once", irq_seen - irq0, 1);

        // 5: done held high as a level
        do_reset;
        push(mk(32'h5000, 32'h5100, 16'h8));
        push(mk(32'h6000, 32'h6100, 16'h8));
        wait_gos(go0 + 1);
        @(negedge clk); dma_done_i = 1'b1;
        @(negedge clk);
        chk("t5_first_done", done_cnt_o, 1);
        wait_gos(go0 + 2);
        tick(4);
        chk("t5_level_no_double", done_cnt_o, 1);
        chk("t5_busy_waiting", busy_o, 1);
        dma_done_i = 1'b0;
        @(negedge clk); dma_done_i = 1'b1;
        @(negedge clk);
        chk("t5_second_done", done_cnt_o, 2);
        dma_done_i = 1'b0;
        tick(2);
        chk("t5_busy_end", busy_o, 0);

        // 6: flush with three queued and one in flight, push in same cycle; then reset in RUN
        do_reset;
        for (int i = 0; i < 4; i++) push(mk(32'h7000 + i, 32'h7100 + i, 16'h40));
        chk("t6_level_before_flush", level_o, 3);
        flush_i = 1'b1; desc_valid_i = 1'b1; desc_i = mk(32'hF00D, 32'hF11D, 16'h4);
        @(negedge clk); flush_i = 1'b0; desc_valid_i = 1'b0;
        exp_q.delete();
        chk("t6_level_flushed", level_o, 0);
        chk("t6_ready_after_flush", desc_ready_o, 1);
        tick(2);
        chk("t6_flush_beats_push", level_o, 0);
        done_pulse;
        chk("t6_done_cnt", done_cnt_o, 1);
        tick(3);
        chk("t6_go_count", go_seen - go0, 1);
        chk("t6_busy", busy_o, 0);
        push(mk(32'h9000, 32'h9100, 16'h80));
        wait_gos(go0 + 2);
        @(negedge clk);
        chk("t6_in_run", busy_o, 1);
        do_reset;

        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
